// File: rtl/latch_phase_gen_pkg.sv
// Shared definitions for the two-phase non-overlapping latch enable generator.
// Holds the default widths and the FSM state encoding used by latch_phase_gen.
package latch_phase_gen_pkg;

    localparam int unsigned CNT_W_DEFAULT = 4;
    localparam int unsigned CYC_W_DEFAULT = 8;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'd0;
    localparam state_t StP1   = 3'd1;
    localparam state_t StG1   = 3'd2;
    localparam state_t StP2   = 3'd3;
    localparam state_t StG2   = 3'd4;

endpackage

// File: rtl/latch_phase_gen_phase_timer.sv
// phase_timer: loadable down-counter that times each FSM state.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset, clears the count
//   load     - load load_val this cycle (takes priority over counting)
//   load_val - value to load; a state lasting N clocks is loaded with N-1
//   tc       - terminal count, high while the count is zero (last clock of a state)
module phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/latch_phase_gen.sv
// latch_phase_gen: generates non-overlapping master/slave latch enables.
// Sequence per cycle: P1 (phi1 high, h clocks), G1 (gap, g clocks),
// P2 (phi2 high, h clocks), G2 (gap, g clocks); repeats until stop.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   start        - begin the sequence (sampled only when idle)
//   stop         - finish after the current full cycle (sticky)
//   high_cycles  - enable high time in clocks (0 behaves as 1), captured at start
//   gap_cycles   - non-overlap gap in clocks (0 behaves as 1), captured at start
//   phi1, phi2   - registered master / slave latch enables
//   busy         - high whenever not idle
//   cycle_cnt    - completed cycle count, wraps, cleared only by reset
module latch_phase_gen
    import latch_phase_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT,
    parameter int unsigned CYC_W = CYC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] gap_cycles,
    output logic             phi1,
    output logic             phi2,
    output logic             busy,
    output logic [CYC_W-1:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CYC_W-1:0] CycOne = CYC_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hm1_q, hm1_d;   // captured high length minus one
    logic [CNT_W-1:0] gm1_q, gm1_d;   // captured gap length minus one
    logic             stop_q, stop_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             phi1_q, phi2_q, busy_q;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc;
    logic [CNT_W-1:0] h_eff, g_eff;

    assign h_eff = (high_cycles == '0) ? CntOne : high_cycles;
    assign g_eff = (gap_cycles == '0) ? CntOne : gap_cycles;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        hm1_d    = hm1_q;
        gm1_d    = gm1_q;
        stop_d   = stop_q;
        cyc_d    = cyc_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        if (state_q != StIdle) begin
            stop_d = stop_q | stop;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    hm1_d    = h_eff - CntOne;
                    gm1_d    = g_eff - CntOne;
                    // Stop seen together with start still allows one full cycle.
                    stop_d   = stop;
                    state_d  = StP1;
                    tmr_load = 1'b1;
                    tmr_val  = h_eff - CntOne;
                end
            end
            StP1: begin
                if (tmr_tc) begin
                    state_d  = StG1;
                    tmr_load = 1'b1;
                    tmr_val  = gm1_q;
                end
            end
            StG1: begin
                if (tmr_tc) begin
                    state_d  = StP2;
                    tmr_load = 1'b1;
                    tmr_val  = hm1_q;
                end
            end
            StP2: begin
                if (tmr_tc) begin
                    state_d  = StG2;
                    tmr_load = 1'b1;
                    tmr_val  = gm1_q;
                end
            end
            StG2: begin
                if (tmr_tc) begin
                    cyc_d = cyc_q + CycOne;
                    if (stop_q || stop) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StP1;
                        tmr_load = 1'b1;
                        tmr_val  = hm1_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered off the next state so they carry no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            hm1_q   <= '0;
            gm1_q   <= '0;
            stop_q  <= 1'b0;
            cyc_q   <= '0;
            phi1_q  <= 1'b0;
            phi2_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hm1_q   <= hm1_d;
            gm1_q   <= gm1_d;
            stop_q  <= stop_d;
            cyc_q   <= cyc_d;
            phi1_q  <= (state_d == StP1);
            phi2_q  <= (state_d == StP2);
            busy_q  <= (state_d != StIdle);
        end
    end

    assign phi1      = phi1_q;
    assign phi2      = phi2_q;
    assign busy      = busy_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_latch_phase_gen.sv
// Scoreboard bench for latch_phase_gen: stimulus pushes the expected per-cycle
// outputs, a monitor pops and compares one entry on every falling clock edge.
module tb_latch_phase_gen;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned CYC_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] high_cycles = '0;
    logic [CNT_W-1:0] gap_cycles = '0;
    logic             phi1, phi2, busy;
    logic [CYC_W-1:0] cycle_cnt;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic             p1;
        logic             p2;
        logic             b;
        logic [CYC_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    latch_phase_gen #(
        .CNT_W (CNT_W),
        .CYC_W (CYC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .high_cycles (high_cycles),
        .gap_cycles  (gap_cycles),
        .phi1        (phi1),
        .phi2        (phi2),
        .busy        (busy),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle while the scoreboard holds any.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({phi1, phi2, busy, cycle_cnt} !== {e.p1, e.p2, e.b, e.cnt}) begin
                bad++;
                $display("FAIL trace t=%0t got phi1=%b phi2=%b busy=%b cnt=%0d want phi1=%b phi2=%b busy=%b cnt=%0d",
                         $time, phi1, phi2, busy, cycle_cnt, e.p1, e.p2, e.b, e.cnt);
            end
        end
    end

    // Non-overlap checker, active for the whole run.
    always @(negedge clk) begin
        total++;
        if (phi1 && phi2) begin
            bad++;
            $display("FAIL overlap t=%0t got phi1=%b phi2=%b want not both high", $time, phi1, phi2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic p1, input logic p2, input logic b, input logic [CYC_W-1:0] c);
        exp_t e;
        e.p1  = p1;
        e.p2  = p2;
        e.b   = b;
        e.cnt = c;
        sb.push_back(e);
    endtask

    // Expected trace of a run launched in the current cycle: this idle cycle, n full
    // cycles of h/g/h/g, then one idle cycle with the final count.
    task automatic push_run(input int h, input int g, input int n, input logic [CYC_W-1:0] c0);
        logic [CYC_W-1:0] c;
        push(1'b0, 1'b0, 1'b0, c0);
        c = c0;
        for (int i = 0; i < n; i++) begin
            repeat (h) push(1'b1, 1'b0, 1'b1, c);
            repeat (g) push(1'b0, 1'b0, 1'b1, c);
            repeat (h) push(1'b0, 1'b1, 1'b1, c);
            repeat (g) push(1'b0, 1'b0, 1'b1, c);
            c = c + CYC_W'(1);
        end
        push(1'b0, 1'b0, 1'b0, c);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout got %0d entries left want 0", name, sb.size());
            sb.delete();
        end
        tick();
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check1("rst_phi1", phi1, 1'b0);
        check1("rst_phi2", phi2, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_cnt0", (cycle_cnt == '0), 1'b1);
        tick();
        rst = 1'b0;
        repeat (2) push(1'b0, 1'b0, 1'b0, '0);
        wait_drain(10, "reset_idle");
    endtask

    initial begin
        tick();
        do_reset();

        // high=2 gap=1: period 6, two cycles, stop pulsed in the second.
        high_cycles = 4'd2;
        gap_cycles  = 4'd1;
        push_run(2, 1, 2, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_drain(40, "run_h2g1");

        // high=0 gap=0 behaves as 1/1: period 4; a start pulse mid-run is ignored.
        high_cycles = 4'd0;
        gap_cycles  = 4'd0;
        push_run(1, 1, 3, 8'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_drain(40, "run_h0g0");

        // high=3 gap=2, high changed to 7 mid-cycle, stop during first P2.
        do_reset();
        high_cycles = 4'd3;
        gap_cycles  = 4'd2;
        push_run(3, 2, 1, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        high_cycles = 4'd7;
        repeat (5) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) push(1'b0, 1'b0, 1'b0, 8'd1);
        wait_drain(40, "run_h3g2_stop");

        // start and stop together in idle: exactly one cycle.
        high_cycles = 4'd2;
        gap_cycles  = 4'd2;
        push_run(2, 2, 1, 8'd1);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) push(1'b0, 1'b0, 1'b0, 8'd2);
        wait_drain(40, "start_stop_same");

        // Asynchronous reset in the middle of P1.
        high_cycles = 4'd3;
        gap_cycles  = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check1("pre_rst_phi1", phi1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check1("async_phi1_low", phi1, 1'b0);
        check1("async_busy_low", busy, 1'b0);
        check1("async_cnt0", (cycle_cnt == '0), 1'b1);
        tick();
        rst = 1'b0;
        repeat (5) push(1'b0, 1'b0, 1'b0, 8'd0);
        wait_drain(20, "post_rst_idle");

        // 256 cycles at 1/1: count wraps back to 0.
        high_cycles = 4'd1;
        gap_cycles  = 4'd1;
        push_run(1, 1, 256, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (255 * 4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_drain(2000, "wrap_256");
        check1("wrap_cnt0", (cycle_cnt == '0), 1'b1);
        check1("wrap_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
